// File: rtl/oven_display_ctrl.sv
// Seven-segment front-panel controller: samples time/temperature every refresh period,
// converts to decimal with a serial /60 divider and a double-dabble engine, drives six active-low digits.
module oven_display_ctrl #(
    parameter int TIME_W         = 13,
    parameter int TEMP_W         = 9,
    parameter int REFRESH_CYCLES = 1000,
    parameter int BLINK_CYCLES   = 25000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              power,
    input  logic [TIME_W-1:0] current_time,
    input  logic [TEMP_W-1:0] current_temp,
    input  logic [TEMP_W-1:0] target_temp,
    output logic [0:6]        hex0,
    output logic [0:6]        hex1,
    output logic [0:6]        hex2,
    output logic [0:6]        hex3,
    output logic [0:6]        hex4,
    output logic [0:6]        hex5,
    output logic              busy,
    output logic              disp_valid
);

    localparam int REF_W  = $clog2(REFRESH_CYCLES + 1);
    localparam int BLK_W  = $clog2(BLINK_CYCLES + 1);
    localparam int STEP_W = $clog2(TIME_W + 10);

    localparam logic [0:6] BLANK = 7'b1111111;
    localparam logic [0:6] DASH  = 7'b1111110;

    typedef enum logic [2:0] {IDLE, CAPTURE, DIV, BCD_A, BCD_B, LOAD} state_t;

    state_t state, state_next;

    logic [REF_W-1:0]  refresh_cnt;
    logic [BLK_W-1:0]  blink_cnt;
    logic              blink_phase;
    logic [STEP_W-1:0] step;
    logic              step_last;
    logic              start;

    logic              power_r;
    logic              zero_time_r;
    logic              heating_r;
    logic [9:0]        cur_clamp_r;
    logic [9:0]        tgt_clamp_r;
    logic [TIME_W-1:0] quo_r;
    logic [5:0]        rem_r;
    logic [9:0]        bin_r;
    logic [9:0]        field_b_r;
    logic [11:0]       bcd_r;
    logic [11:0]       bcd_a_r;
    logic [0:6]        hex_r [6];
    logic              mode_r;
    logic              blink_en_r;

    logic [6:0]        trial;
    logic              trial_ge;
    logic [TIME_W-1:0] quo_next;
    logic [5:0]        rem_next;
    logic              min_over;
    logic [9:0]        min_field;
    logic [9:0]        sec_field;
    logic [11:0]       bcd_adj;
    logic [11:0]       bcd_next;
    logic [0:6]        hex_next [6];

    function automatic logic [0:6] seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return BLANK;
        endcase
    endfunction

    function automatic logic [9:0] clamp_to(input logic [31:0] v, input logic [31:0] lim);
        return (v > lim) ? lim[9:0] : v[9:0];
    endfunction

    assign start = (refresh_cnt == '0) && (state == IDLE);
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
        end else if (refresh_cnt == REF_W'(REFRESH_CYCLES - 1)) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLK_W'(BLINK_CYCLES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        step_last  = 1'b0;
        unique case (state)
            IDLE:    if (start) state_next = CAPTURE;
            CAPTURE: state_next = DIV;
            DIV: begin
                step_last = (step == STEP_W'(TIME_W - 1));
                if (step_last) state_next = BCD_A;
            end
            BCD_A: begin
                step_last = (step == STEP_W'(9));
                if (step_last) state_next = BCD_B;
            end
            BCD_B: begin
                step_last = (step == STEP_W'(9));
                if (step_last) state_next = LOAD;
            end
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One restoring-division step and one double-dabble step per clock.
    always_comb begin
        trial     = {rem_r, quo_r[TIME_W-1]};
        trial_ge  = (trial >= 7'd60);
        quo_next  = {quo_r[TIME_W-2:0], trial_ge};
        rem_next  = trial_ge ? 6'(trial - 7'd60) : trial[5:0];
        min_over  = (32'(quo_next) > 32'd99);
        min_field = clamp_to(32'(quo_next), 32'd99);
        sec_field = min_over ? 10'd59 : 10'(rem_next);
        for (int i = 0; i < 3; i++) begin
            bcd_adj[4*i +: 4] = (bcd_r[4*i +: 4] >= 4'd5) ? bcd_r[4*i +: 4] + 4'd3 : bcd_r[4*i +: 4];
        end
        bcd_next = {bcd_adj[10:0], bin_r[9]};
    end

    always_comb begin
        for (int i = 0; i < 6; i++) hex_next[i] = BLANK;
        if (!power_r) begin
            hex_next[4] = seg(bcd_a_r[7:4]);
            hex_next[3] = seg(bcd_a_r[3:0]);
            hex_next[2] = DASH;
            hex_next[1] = seg(bcd_r[7:4]);
            hex_next[0] = seg(bcd_r[3:0]);
        end else begin
            // Leading zeros blank; the ones digit always shows.
            hex_next[5] = (bcd_r[11:8] == 4'd0)   ? BLANK : seg(bcd_r[11:8]);
            hex_next[4] = (bcd_r[11:4] == 8'd0)   ? BLANK : seg(bcd_r[7:4]);
            hex_next[3] = seg(bcd_r[3:0]);
            hex_next[2] = (bcd_a_r[11:8] == 4'd0) ? BLANK : seg(bcd_a_r[11:8]);
            hex_next[1] = (bcd_a_r[11:4] == 8'd0) ? BLANK : seg(bcd_a_r[7:4]);
            hex_next[0] = seg(bcd_a_r[3:0]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step        <= '0;
            power_r     <= 1'b0;
            zero_time_r <= 1'b0;
            heating_r   <= 1'b0;
            cur_clamp_r <= '0;
            tgt_clamp_r <= '0;
            quo_r       <= '0;
            rem_r       <= '0;
            bin_r       <= '0;
            field_b_r   <= '0;
            bcd_r       <= '0;
            bcd_a_r     <= '0;
            mode_r      <= 1'b0;
            blink_en_r  <= 1'b0;
            disp_valid  <= 1'b0;
            // NOTE: the hex registers are plain flops driving pins, so they are reset to blank like any other state.
            for (int i = 0; i < 6; i++) hex_r[i] <= BLANK;
        end else begin
            step <= (state == IDLE || state_next != state) ? '0 : step + 1'b1;
            unique case (state)
                CAPTURE: begin
                    power_r     <= power;
                    zero_time_r <= (current_time == '0);
                    heating_r   <= (current_temp < target_temp);
                    cur_clamp_r <= clamp_to(32'(current_temp), 32'd999);
                    tgt_clamp_r <= clamp_to(32'(target_temp), 32'd999);
                    quo_r       <= current_time;
                    rem_r       <= '0;
                end
                DIV: begin
                    quo_r <= quo_next;
                    rem_r <= rem_next;
                    if (step_last) begin
                        bin_r     <= power_r ? cur_clamp_r : min_field;
                        field_b_r <= power_r ? tgt_clamp_r : sec_field;
                        bcd_r     <= '0;
                    end
                end
                BCD_A: begin
                    if (step_last) begin
                        bcd_a_r <= bcd_next;
                        bin_r   <= field_b_r;
                        bcd_r   <= '0;
                    end else begin
                        bin_r <= {bin_r[8:0], 1'b0};
                        bcd_r <= bcd_next;
                    end
                end
                BCD_B: begin
                    bin_r <= {bin_r[8:0], 1'b0};
                    bcd_r <= bcd_next;
                end
                LOAD: begin
                    for (int i = 0; i < 6; i++) hex_r[i] <= hex_next[i];
                    mode_r     <= power_r;
                    blink_en_r <= power_r ? heating_r : zero_time_r;
                    disp_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    logic blank_lo, blank_mid;
    assign blank_lo  = blink_phase & blink_en_r;
    assign blank_mid = blank_lo & ~mode_r;

    assign hex0 = blank_lo  ? BLANK : hex_r[0];
    assign hex1 = blank_lo  ? BLANK : hex_r[1];
    assign hex2 = blank_lo  ? BLANK : hex_r[2];
    assign hex3 = blank_mid ? BLANK : hex_r[3];
    assign hex4 = blank_mid ? BLANK : hex_r[4];
    assign hex5 = hex_r[5];

endmodule
